md_unit: RTL

HI/LO multiply/divide execution unit in the EX stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu and mthi/mtlo from EX.
- Runs multi-cycle operations and owns the HI/LO registers.
- Raises `busy`, which the hazard/forwarding unit consumes as its EX md-busy input to stall mfhi/mflo and further md ops in ID.
- Supplies HI/LO values for mfhi/mflo reads.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_div_iter.sv | 25 ++
 rtl/md_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  localparam int unsigned DIV_ITERS   = 32;
  localparam int unsigned DIV_LAT     = DIV_ITERS + 1;
  localparam int unsigned MUL_LAT_DEF = 4;

  function automatic logic [31:0] md_abs(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// One restoring-divide step: shift in the next dividend bit, try subtract.
module md_div_iter (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] sh;
  logic [32:0] diff;

  always_comb begin
    sh   = {rem_i, quo_i[31]};
    diff = sh - {1'b0, dvs_i};
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = sh[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit; MD_DIV_EARLY_EN enables the divide
// early-out when the quotient is trivially zero or the divisor is zero.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [31:0] hi_q, lo_q;
  logic        negq_q, negr_q;
  logic        busy_q, done_q;
`ifdef MD_DIV_EARLY_EN
  logic        early_q;
`endif

  logic        sgn;
  logic [31:0] abs_a, abs_b;
  logic [63:0] ext_a, ext_b, prod_d;
  logic [31:0] rem_d, quo_d;
  logic [31:0] dhi_d, dlo_d;

  assign sgn   = ~op_q[0];
  assign abs_a = md_abs(a_q, sgn);
  assign abs_b = md_abs(b_q, sgn);

  always_comb begin
    ext_a  = sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b  = sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod_d = ext_a * ext_b;
  end

  md_div_iter u_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // Final step result with sign fix-up and the fixed boundary results.
  always_comb begin
    dlo_d = negq_q ? -quo_d : quo_d;
    dhi_d = negr_q ? -rem_d : rem_d;
    if (b_q == 32'd0) begin
      dlo_d = 32'hFFFF_FFFF;
      dhi_d = a_q;
`ifdef MD_DIV_EARLY_EN
    end else if (early_q) begin
      dlo_d = 32'd0;
      dhi_d = a_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MD_DIV_EARLY_EN
      early_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (cancel) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              op_q    <= md_op;
              a_q     <= src_a;
              b_q     <= src_b;
              busy_q  <= 1'b1;
              state_q <= md_op[1] ? DIV : MUL;
              cnt_q   <= md_op[1] ? 6'(DIV_LAT) : 6'(MUL_LAT);
            end else begin
              if (wr_hi) hi_q <= src_a;
              if (wr_lo) lo_q <= src_a;
            end
          end
          MUL: begin
            if (cnt_q == 6'd1) begin
              hi_q    <= prod_d[63:32];
              lo_q    <= prod_d[31:0];
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
            cnt_q <= cnt_q - 6'd1;
          end
          DIV: begin
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'(DIV_LAT)) begin
              rem_q  <= '0;
              quo_q  <= abs_a;
              dvs_q  <= abs_b;
              negq_q <= sgn & (a_q[31] ^ b_q[31]);
              negr_q <= sgn & a_q[31];
`ifdef MD_DIV_EARLY_EN
              early_q <= (b_q == 32'd0) || (abs_a < abs_b);
              if ((b_q == 32'd0) || (abs_a < abs_b)) cnt_q <= 6'd1;
`endif
            end else if (cnt_q == 6'd1) begin
              hi_q    <= dhi_d;
              lo_q    <= dlo_d;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              rem_q <= rem_d;
              quo_q <= quo_d;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
